id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Decode stage: field extraction, immediate generation, hazard detection and a
// one-entry output register. Define ID_FORWARD_EN to forward EX/MEM results instead of stalling.
module id_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_inst,
    output logic            re1,
    output logic            re2,
    output logic [RAW-1:0]  raddr1,
    output logic [RAW-1:0]  raddr2,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic            ex_wreg,
    input  logic            ex_is_load,
    input  logic [RAW-1:0]  ex_waddr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic            mem_wreg,
    input  logic [RAW-1:0]  mem_waddr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [RAW-1:0]  out_rd,
    output logic            out_wreg
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]         w_opcode;
    logic [RAW-1:0]     w_rd;
    logic               w_re1;
    logic               w_re2;
    logic               w_wr_class;
    logic signed [31:0] w_imm32;
    logic               w_use1;
    logic               w_use2;
    logic               w_hz1_ex;
    logic               w_hz2_ex;
    logic               w_hz1_mem;
    logic               w_hz2_mem;
    logic               w_stall;
    logic               w_in_ready;
    logic               w_load;
    logic [XLEN-1:0]    w_op1;
    logic [XLEN-1:0]    w_op2;

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_op1;
    logic [XLEN-1:0]    r_op2;
    logic [XLEN-1:0]    r_imm;
    logic [6:0]         r_opcode;
    logic [2:0]         r_funct3;
    logic               r_funct7b5;
    logic [RAW-1:0]     r_rd;
    logic               r_wreg;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = RAW'(in_inst[11:7]);
    assign raddr1   = RAW'(in_inst[19:15]);
    assign raddr2   = RAW'(in_inst[24:20]);
    assign re1      = w_re1;
    assign re2      = w_re2;

    // Opcode decode: read enables, writeback class and format-specific immediate
    always_comb begin
        w_re1      = 1'b1;
        w_re2      = 1'b0;
        w_wr_class = 1'b0;
        w_imm32    = 32'sd0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_re1      = 1'b0;
                w_wr_class = 1'b1;
                w_imm32    = {in_inst[31:12], 12'h000};
            end
            OPC_JAL: begin
                w_re1      = 1'b0;
                w_wr_class = 1'b1;
                w_imm32    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                w_wr_class = 1'b1;
                w_imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_BRANCH: begin
                w_re2   = 1'b1;
                w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OPC_STORE: begin
                w_re2   = 1'b1;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_OP: begin
                w_re2      = 1'b1;
                w_wr_class = 1'b1;
            end
            default: begin
                w_re1 = 1'b1;
            end
        endcase
    end

    // x0 is never a hazard and never forwarded
    assign w_use1    = w_re1 && (raddr1 != {RAW{1'b0}});
    assign w_use2    = w_re2 && (raddr2 != {RAW{1'b0}});
    assign w_hz1_ex  = w_use1 && ex_wreg  && (ex_waddr  == raddr1);
    assign w_hz2_ex  = w_use2 && ex_wreg  && (ex_waddr  == raddr2);
    assign w_hz1_mem = w_use1 && mem_wreg && (mem_waddr == raddr1);
    assign w_hz2_mem = w_use2 && mem_wreg && (mem_waddr == raddr2);

`ifdef ID_FORWARD_EN
    assign w_stall = ex_is_load && (w_hz1_ex || w_hz2_ex);
    assign w_op1   = !w_use1 ? {XLEN{1'b0}} : w_hz1_ex ? ex_wdata : w_hz1_mem ? mem_wdata : rdata1;
    assign w_op2   = !w_use2 ? {XLEN{1'b0}} : w_hz2_ex ? ex_wdata : w_hz2_mem ? mem_wdata : rdata2;
`else
    logic w_unused;
    assign w_unused = ^{ex_is_load, ex_wdata, mem_wdata};
    assign w_stall  = w_hz1_ex || w_hz2_ex || w_hz1_mem || w_hz2_mem;
    assign w_op1    = w_use1 ? rdata1 : {XLEN{1'b0}};
    assign w_op2    = w_use2 ? rdata2 : {XLEN{1'b0}};
`endif

    assign w_in_ready = rst && rdy && !w_stall && (!r_valid || out_ready);
    assign w_load     = in_valid && w_in_ready;
    assign in_ready   = w_in_ready;

    // Output register: flush beats load, consumption without a load empties it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_pc       <= {XLEN{1'b0}};
            r_op1      <= {XLEN{1'b0}};
            r_op2      <= {XLEN{1'b0}};
            r_imm      <= {XLEN{1'b0}};
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_rd       <= {RAW{1'b0}};
            r_wreg     <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid    <= 1'b1;
                r_pc       <= in_pc;
                r_op1      <= w_op1;
                r_op2      <= w_op2;
                r_imm      <= XLEN'(w_imm32);
                r_opcode   <= w_opcode;
                r_funct3   <= in_inst[14:12];
                r_funct7b5 <= in_inst[30];
                r_rd       <= w_rd;
                r_wreg     <= w_wr_class && (w_rd != {RAW{1'b0}});
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_op1      = r_op1;
    assign out_op2      = r_op2;
    assign out_imm      = r_imm;
    assign out_opcode   = r_opcode;
    assign out_funct3   = r_funct3;
    assign out_funct7b5 = r_funct7b5;
    assign out_rd       = r_rd;
    assign out_wreg     = r_wreg;
endmodule
